// File: rtl/bht_update_sched.sv
// bht_update_sched: commit-to-BHT update queue with table init sweep when BHT_INIT_SWEEP_EN is defined
module bht_update_sched #(
    parameter int AMSB = 51,
    parameter int TBLSZ = 4096,
    parameter int QDEPTH = 16,
    parameter logic [1:0] INIT_VAL = 2'd3,
    localparam int IW = $clog2(TBLSZ),
    localparam int QW = $clog2(QDEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            cmt_valid,
    input  logic [4*(AMSB+1)-1:0] cmt_ip,
    input  logic [3:0]            cmt_takb,
    output logic                  cmt_ready,
    input  logic                  clr_req,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [AMSB:0]         upd_ip,
    output logic                  upd_takb,
    output logic                  init_we,
    output logic [IW-1:0]         init_addr,
    output logic [1:0]            init_val,
    output logic                  pred_en,
    output logic [15:0]           stall_cnt
);
    logic               run;
    logic [QW-1:0]      wr_ptr, rd_ptr;
    logic [QW:0]        count;
    logic [AMSB:0]      ip_q [QDEPTH];
    logic [QDEPTH-1:0]  tk_q;
    logic [3:0]         en;
    logic [3:0][2:0]    off;
    logic [2:0]         n_enq, enq_n;
    logic               stop, deq;
`ifdef BHT_INIT_SWEEP_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t        state, state_n;
    logic [IW-1:0] addr, addr_n;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= INIT;
            addr  <= '0;
        end else begin
            state <= state_n;
            addr  <= addr_n;
        end
    end
    always_comb begin
        state_n = state;
        addr_n  = addr;
        if (clr_req) begin
            state_n = INIT;
            addr_n  = '0;
        end else if (state == INIT) begin
            state_n = (addr == IW'(TBLSZ - 1)) ? RUN : INIT;
            addr_n  = (addr == IW'(TBLSZ - 1)) ? '0 : addr + 1'b1;
        end
    end
    assign run       = (state == RUN);
    assign init_we   = (state == INIT);
    assign init_addr = addr;
`else
    always_ff @(posedge clk) begin
        run <= rst_n;
    end
    assign init_we   = 1'b0;
    assign init_addr = '0;
`endif
    assign init_val = INIT_VAL;
    assign pred_en  = run;
    // A group is cut after its first taken branch: younger slots are wrong-path.
    always_comb begin
        en    = '0;
        off   = '0;
        n_enq = '0;
        stop  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            off[i] = n_enq;
            en[i]  = cmt_valid[i] && !stop;
            n_enq  = n_enq + {2'b0, en[i]};
            stop   = stop | (en[i] && cmt_takb[i]);
        end
    end
    assign cmt_ready = run && (count <= (QW+1)'(QDEPTH - 4)) && !clr_req;
    assign enq_n     = cmt_ready ? n_enq : 3'd0;
    assign upd_valid = run && (count != '0);
    assign deq       = upd_valid && upd_ready;
    assign upd_ip    = ip_q[rd_ptr];
    assign upd_takb  = tk_q[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n || clr_req) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + QW'(enq_n);
            rd_ptr <= rd_ptr + QW'(deq);
            count  <= count + (QW+1)'(enq_n) - (QW+1)'(deq);
        end
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (cmt_ready && en[i]) begin
                ip_q[wr_ptr + QW'(off[i])] <= cmt_ip[i*(AMSB+1) +: AMSB+1];
                tk_q[wr_ptr + QW'(off[i])] <= cmt_takb[i];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (|cmt_valid && !cmt_ready && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
endmodule

// File: tb/tb_bht_update_sched.sv
// tb_bht_update_sched: randomized scoreboard bench for bht_update_sched (handles BHT_INIT_SWEEP_EN on or off)
module tb_bht_update_sched;
    localparam int W = 52;
    localparam int TBL = 4096;
    typedef struct packed { logic [W-1:0] ip; logic tk; } ent_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [3:0]     cmt_valid = '0;
    logic [4*W-1:0] cmt_ip = '0;
    logic [3:0]     cmt_takb = '0;
    logic           cmt_ready;
    logic           clr_req = 1'b0;
    logic           upd_valid;
    logic           upd_ready = 1'b0;
    logic [W-1:0]   upd_ip;
    logic           upd_takb;
    logic           init_we;
    logic [11:0]    init_addr;
    logic [1:0]     init_val;
    logic           pred_en;
    logic [15:0]    stall_cnt;

    bht_update_sched dut (
        .clk(clk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_ip(cmt_ip),
        .cmt_takb(cmt_takb), .cmt_ready(cmt_ready), .clr_req(clr_req),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_ip(upd_ip),
        .upd_takb(upd_takb), .init_we(init_we), .init_addr(init_addr),
        .init_val(init_val), .pred_en(pred_en), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad = 0;
    ent_t exp_q[$];
    bit   known = 0;
    bit   run_m = 0;
    int   sa = 0;
    int   stall_m = 0;

    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    // Reference: the queue is exp_q itself; occupancy is its size.
    task automatic step();
        bit er;
        #1;
        er = run_m && exp_q.size() <= 12 && !clr_req;
        if (known) begin
            chk("cmt_ready", 64'(cmt_ready), 64'(er));
            chk("upd_valid", 64'(upd_valid), 64'(run_m && exp_q.size() > 0));
            chk("pred_en", 64'(pred_en), 64'(run_m));
            chk("stall_cnt", 64'(stall_cnt), 64'(stall_m));
            chk("init_val", 64'(init_val), 64'd3);
`ifdef BHT_INIT_SWEEP_EN
            chk("init_we", 64'(init_we), 64'(!run_m));
            chk("init_addr", 64'(init_addr), 64'(run_m ? 0 : sa));
`else
            chk("init_we", 64'(init_we), 64'd0);
            chk("init_addr", 64'(init_addr), 64'd0);
`endif
        end
        if (!rst_n) begin
            exp_q.delete();
            run_m = 0;
            sa = 0;
            stall_m = 0;
            known = 1;
        end else begin
            if (|cmt_valid && !er && stall_m < 65535) stall_m++;
            if (clr_req) begin
                exp_q.delete();
`ifdef BHT_INIT_SWEEP_EN
                run_m = 0;
                sa = 0;
`endif
            end else begin
                if (er)
                    for (int i = 0; i < 4; i++)
                        if (cmt_valid[i]) begin
                            exp_q.push_back('{ip: cmt_ip[i*W +: W], tk: cmt_takb[i]});
                            if (cmt_takb[i]) break;
                        end
`ifdef BHT_INIT_SWEEP_EN
                if (!run_m) begin
                    if (sa == TBL - 1) begin
                        run_m = 1;
                        sa = 0;
                    end else sa++;
                end
`else
                run_m = 1;
`endif
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every accepted update must match the oldest outstanding expectation.
    always @(negedge clk) begin
        #2;
        if (rst_n && !clr_req && upd_valid === 1'b1 && upd_ready) begin
            if (exp_q.size() == 0) chk("upd_unexpected", 64'd1, 64'd0);
            else begin
                chk("upd_ip", 64'(upd_ip), 64'(exp_q[0].ip));
                chk("upd_takb", 64'(upd_takb), 64'(exp_q[0].tk));
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic rand_ip();
        for (int i = 0; i < 4; i++) cmt_ip[i*W +: W] = W'({$urandom(), $urandom()});
    endtask

    task automatic wait_run();
        int n = 0;
        while (!run_m && n < 10000) begin
            step();
            n++;
        end
        if (!run_m) chk("run_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        @(negedge clk);
        rst_n = 0;
        step();
        step();
        rst_n = 1;
        wait_run();
        upd_ready = 1;
        rand_ip();
        cmt_valid = 4'b1111;
        cmt_takb = 4'b0010;
        step();
        cmt_valid = 0;
        repeat (4) step();
        upd_ready = 0;
        cmt_takb = 0;
        cmt_valid = 4'b1111;
        repeat (8) begin
            rand_ip();
            step();
        end
        cmt_valid = 0;
        upd_ready = 1;
        repeat (20) step();
        upd_ready = 0;
        rand_ip();
        cmt_valid = 4'b1111;
        step();
        cmt_valid = 4'b0001;
        step();
        cmt_valid = 0;
        clr_req = 1;
        step();
        clr_req = 0;
        upd_ready = 1;
        repeat (3) step();
`ifdef BHT_INIT_SWEEP_EN
        while (sa != 2000 && !run_m) step();
`endif
        rst_n = 0;
        step();
        rst_n = 1;
        wait_run();
        for (int c = 0; c < 3000; c++) begin
            rand_ip();
            cmt_valid = 4'($urandom());
            cmt_takb = 4'($urandom()) & 4'($urandom());
            upd_ready = ($urandom_range(0, 2) != 0);
            clr_req = ($urandom_range(0, 599) == 0);
            step();
            clr_req = 0;
        end
        cmt_valid = 0;
        upd_ready = 1;
        wait_run();
        repeat (20) step();
        chk("drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bht_update_sched.md
BHT_UPDATE_SCHED -- requirements
Module: bht_update_sched

Interface
REQ-001 Parameter AMSB, 51, MSB of instruction address.
REQ-002 Parameter TBLSZ, 4096, predictor table entries (power of two); IW = log2(TBLSZ).
REQ-003 Parameter QDEPTH, 16, update queue entries (power of two, >= 8).
REQ-004 Parameter INIT_VAL, 2'd3, counter value written by the init sweep.
REQ-005 clk  in  1  single clock; all logic on posedge clk.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 cmt_valid  in  4  per-commit-slot branch-retire valid, slot 0 oldest.
REQ-008 cmt_ip  in  4x(AMSB+1)  per-slot branch address.
REQ-009 cmt_takb  in  4  per-slot branch-taken outcome.
REQ-010 cmt_ready  out  1  commit group accepted this cycle.
REQ-011 clr_req  in  1  single-cycle pulse: discard queue and reinitialise table.
REQ-012 upd_valid / upd_ready  out / in  1 / 1  predictor update handshake.
REQ-013 upd_ip  out  AMSB+1  update address; upd_takb  out  1  update outcome.
REQ-014 init_we  out  1  table init write strobe; init_addr  out  IW  index; init_val  out  2  = INIT_VAL.
REQ-015 pred_en  out  1  predictor lookup/update enable; stall_cnt  out  16  commit stall count.

Function
REQ-016 FSM states INIT, RUN; exactly one active.
REQ-017 INIT: init_we=1, init_addr increments by 1 per cycle from 0; after issuing TBLSZ-1, next state RUN, init_addr returns to 0.
REQ-018 INIT: cmt_ready=0, upd_valid=0, pred_en=0; RUN: pred_en=1, init_we=0.
REQ-019 cmt_ready = (state==RUN) && free_entries >= 4 && !clr_req; group acceptance all-or-nothing.
REQ-020 On acceptance, enqueue in slot order 0..3 each valid slot up to and including the first valid slot with cmt_takb=1; later slots dropped.
REQ-021 Occupancy changes by (enqueued - dequeued) per cycle; simultaneous enqueue and dequeue in one cycle legal, including at full-minus-4 and at 1 entry.
REQ-022 Pointers wrap modulo QDEPTH; never overflow or underflow.
REQ-023 upd_valid = (state==RUN) && queue non-empty; upd_ip/upd_takb from head entry.
REQ-024 Dequeue on upd_valid && upd_ready; once asserted, upd_valid and data held stable until handshake, except on clr_req or reset.
REQ-025 Latency: entry enqueued at edge N presented on upd_* in the cycle after edge N if the queue was empty; no bypass.
REQ-026 clr_req in RUN: queue emptied at next edge, state INIT, init_addr=0; in INIT: sweep restarts at 0.
REQ-027 clr_req with simultaneous valid commit group: group not accepted (cmt_ready=0).
REQ-028 stall_cnt increments when |cmt_valid && !cmt_ready; saturates at 16'hFFFF.

Reset
REQ-029 rst_n=0 at posedge clk: state INIT, queue empty, init_addr=0, stall_cnt=0, cmt_ready=0, upd_valid=0, pred_en=0.
REQ-030 Reset mid-sweep or mid-drain restarts sweep at 0; queued entries lost.

Configuration
REQ-031 Macro BHT_INIT_SWEEP_EN: defined -> INIT behaviour per REQ-017..018 after reset and clr_req.
REQ-032 Macro undefined -> no INIT state, reset and clr_req go directly to RUN, init_we tied 0, init_addr tied 0; clr_req only empties queue.

Verification
REQ-033 Release reset (macro on) -> init_we high 4096 cycles, addr 0..4095, then pred_en=1, cmt_ready=1.
REQ-034 RUN, cmt_valid=4'b1111, cmt_takb=4'b0010, upd_ready=1 -> exactly 2 updates (slot 0 not-taken, slot 1 taken), next cycles in order.
REQ-035 upd_ready=0, commit 4 branches/cycle -> after 3 groups (12 entries) cmt_ready=1, then fourth group brings 16, cmt_ready=0; stall_cnt increments per stalled cycle.
REQ-036 Queue holding 5 entries, clr_req pulse -> upd_valid=0 next cycle, sweep restarts at init_addr=0, entries never presented.
REQ-037 rst_n low at init_addr=2000 -> after release sweep restarts from 0; macro off -> pred_en=1 one cycle after reset release, init_we never asserted.
